egress_arbiter: RTL and testbench

- Egress-side counterpart of the per-port ingress filters.
- Collects the filtered, destination-tagged AXI-Stream outputs of NUM_INPUTS ingress filters and arbitrates round-robin at packet granularity.
- Accepts only packets whose tdest matches PORT_ID and replays them on one plain AXI-Stream egress port.
- Output is registered through a 2-entry skid buffer, so out_tready has no combinational path to in_tready.

---
 rtl/filter_defs_pkg.sv | 29 ++
 rtl/axis_skid_buffer.sv | 62 ++++++
 rtl/egress_arbiter.sv | 154 +++++++++++++++
 tb/tb_egress_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_defs_pkg.sv
// rtl/filter_defs_pkg.sv - shared stream types and constants for ingress filters and egress arbiter
// Contents:
//   AXIS_DATA_W     stream data width
//   DEST_W          destination tag width
//   axis_d_source_t destination-tagged stream source bundle
//   axis_sink_t     stream sink bundle
//   egress_state_e  egress arbiter state encoding
package filter_defs_pkg;

  localparam int AXIS_DATA_W = 16;
  localparam int DEST_W      = 2;

  typedef struct packed {
    logic                   tvalid;
    logic [AXIS_DATA_W-1:0] tdata;
    logic                   tlast;
    logic [DEST_W-1:0]      tdest;
  } axis_d_source_t;

  typedef struct packed {
    logic tready;
  } axis_sink_t;

  typedef enum logic {
    IDLE    = 1'b0,
    FORWARD = 1'b1
  } egress_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - two-entry registered stream buffer carrying data plus last
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   in_tvalid/in_tdata/in_tlast      upstream word
//   in_tready                        upstream ready, depends on occupancy only
//   out_tvalid/out_tdata/out_tlast   downstream word, driven from storage
//   out_tready                       downstream ready
module axis_skid_buffer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_tvalid,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic              in_tlast,
  output logic              in_tready,
  output logic              out_tvalid,
  output logic [DATA_W-1:0] out_tdata,
  output logic              out_tlast,
  input  logic              out_tready
);

  logic [DATA_W:0] mem0;
  logic [DATA_W:0] mem1;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;

  // Ready is a pure function of registered occupancy, so downstream ready
  // never reaches upstream ready combinationally.
  assign in_tready  = (count != 2'd2);
  assign out_tvalid = (count != 2'd0);
  assign push       = in_tvalid && in_tready;
  assign pop        = out_tvalid && out_tready;

  assign {out_tlast, out_tdata} = rd_ptr ? mem1 : mem0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) mem1 <= {in_tlast, in_tdata};
        else        mem0 <= {in_tlast, in_tdata};
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/egress_arbiter.sv
// rtl/egress_arbiter.sv - packet-granular round-robin egress arbiter with destination filter
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   en                      arbitration enable (packet in flight always completes)
//   in_tvalid/in_tdata/in_tlast/in_tdest   NUM_INPUTS packed ingress streams
//   in_tready               per-input ready, only the granted input can be ready
//   out_tvalid/out_tdata/out_tlast/out_tready   egress stream
//   pkt_count               packets fully emitted, wrapping
//   err_oversize            sticky, set when a packet is force-terminated
module egress_arbiter
  import filter_defs_pkg::*;
#(
  parameter int NUM_INPUTS    = 4,
  parameter int PORT_ID       = 0,
  parameter int MAX_PKT_WORDS = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic [NUM_INPUTS-1:0]             in_tvalid,
  input  logic [NUM_INPUTS*AXIS_DATA_W-1:0] in_tdata,
  input  logic [NUM_INPUTS-1:0]             in_tlast,
  input  logic [NUM_INPUTS*DEST_W-1:0]      in_tdest,
  output logic [NUM_INPUTS-1:0]             in_tready,
  output logic                              out_tvalid,
  output logic [AXIS_DATA_W-1:0]            out_tdata,
  output logic                              out_tlast,
  input  logic                              out_tready,
  output logic [15:0]                       pkt_count,
  output logic                              err_oversize
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int CNT_W = $clog2(MAX_PKT_WORDS) + 1;

  egress_state_e  state, state_next;
  logic [IDX_W-1:0] grant, grant_next;
  logic [IDX_W-1:0] rr_ptr, rr_next;
  logic [CNT_W-1:0] word_cnt, cnt_next;

  axis_d_source_t        src [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] cand;

  logic                   push_valid;
  logic [AXIS_DATA_W-1:0] push_data;
  logic                   push_last;
  logic                   skid_ready;
  logic                   accept;
  logic                   forced;
  logic                   err_set;

  // First candidate at or after ptr, wrapping. Scanning from the far end
  // downwards lets the nearest candidate overwrite farther ones.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_INPUTS-1:0] c,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    pick = ptr;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_INPUTS);
      if (c[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] rr_inc(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(NUM_INPUTS - 1)) ? '0 : g + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      src[i].tvalid = in_tvalid[i];
      src[i].tdata  = in_tdata[i*AXIS_DATA_W +: AXIS_DATA_W];
      src[i].tlast  = in_tlast[i];
      src[i].tdest  = in_tdest[i*DEST_W +: DEST_W];
      cand[i]       = in_tvalid[i] && (in_tdest[i*DEST_W +: DEST_W] == DEST_W'(PORT_ID));
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    rr_next    = rr_ptr;
    cnt_next   = word_cnt;
    in_tready  = '0;
    push_valid = 1'b0;
    push_data  = src[grant].tdata;
    push_last  = 1'b0;
    accept     = 1'b0;
    forced     = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (en && (|cand)) begin
          grant_next = rr_pick(cand, rr_ptr);
          state_next = FORWARD;
        end
      end
      FORWARD: begin
        // tdest is not re-examined here; it was qualified at grant time.
        in_tready[grant] = skid_ready;
        push_valid       = src[grant].tvalid;
        accept           = push_valid && skid_ready;
        forced           = (word_cnt == CNT_W'(MAX_PKT_WORDS - 1)) && !src[grant].tlast;
        push_last        = src[grant].tlast || forced;
        if (accept) begin
          if (push_last) begin
            state_next = IDLE;
            rr_next    = rr_inc(grant);
            cnt_next   = '0;
            err_set    = forced;
          end else begin
            cnt_next = word_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      grant        <= '0;
      rr_ptr       <= '0;
      word_cnt     <= '0;
      pkt_count    <= '0;
      err_oversize <= 1'b0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      rr_ptr   <= rr_next;
      word_cnt <= cnt_next;
      if (out_tvalid && out_tready && out_tlast) pkt_count <= pkt_count + 16'd1;
      if (err_set) err_oversize <= 1'b1;
    end
  end

  axis_skid_buffer #(
    .DATA_W(AXIS_DATA_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .in_tvalid  (push_valid),
    .in_tdata   (push_data),
    .in_tlast   (push_last),
    .in_tready  (skid_ready),
    .out_tvalid (out_tvalid),
    .out_tdata  (out_tdata),
    .out_tlast  (out_tlast),
    .out_tready (out_tready)
  );

endmodule

// File: tb/tb_egress_arbiter.sv
// tb/tb_egress_arbiter.sv - scoreboard bench for egress_arbiter
module tb_egress_arbiter;
  import filter_defs_pkg::*;

  localparam int N    = 4;
  localparam int MAXW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en;
  logic                   tv   [N];
  logic [AXIS_DATA_W-1:0] td   [N];
  logic                   tl   [N];
  logic [DEST_W-1:0]      tdst [N];

  logic [N-1:0]             in_tvalid;
  logic [N*AXIS_DATA_W-1:0] in_tdata;
  logic [N-1:0]             in_tlast;
  logic [N*DEST_W-1:0]      in_tdest;
  logic [N-1:0]             in_tready;
  logic                     out_tvalid;
  logic [AXIS_DATA_W-1:0]   out_tdata;
  logic                     out_tlast;
  logic                     out_tready;
  logic [15:0]              pkt_count;
  logic                     err_oversize;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_tvalid[i]                           = tv[i];
      in_tdata[i*AXIS_DATA_W +: AXIS_DATA_W] = td[i];
      in_tlast[i]                            = tl[i];
      in_tdest[i*DEST_W +: DEST_W]           = tdst[i];
    end
  end

  egress_arbiter #(
    .NUM_INPUTS   (N),
    .PORT_ID      (0),
    .MAX_PKT_WORDS(MAXW)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .en          (en),
    .in_tvalid   (in_tvalid),
    .in_tdata    (in_tdata),
    .in_tlast    (in_tlast),
    .in_tdest    (in_tdest),
    .in_tready   (in_tready),
    .out_tvalid  (out_tvalid),
    .out_tdata   (out_tdata),
    .out_tlast   (out_tlast),
    .out_tready  (out_tready),
    .pkt_count   (pkt_count),
    .err_oversize(err_oversize)
  );

  typedef struct {
    logic [15:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [15:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the last word is taken.
  task automatic drive_pkt(input int p, input logic [15:0] base, input logic [15:0] step,
                           input int n, input logic [1:0] dest);
    int   c;
    logic got;
    for (int k = 0; k < n; k++) begin
      tv[p]   = 1'b1;
      td[p]   = base + step * 16'(k);
      tl[p]   = (k == n - 1);
      tdst[p] = dest;
      c   = 0;
      got = 1'b0;
      while (!got && c < 200) begin
        @(negedge clk);
        got = in_tready[p];
        @(posedge clk);
        #1;
        c++;
      end
      if (!got) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: input %0d word %0d not accepted, got timeout, expected ready", p, k);
        tv[p] = 1'b0;
        tl[p] = 1'b0;
        return;
      end
    end
    tv[p] = 1'b0;
    tl[p] = 1'b0;
  endtask

  task automatic drain(input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < 500) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_tready"}, in_tready, 0);
    check({tag, "_out_tvalid"}, out_tvalid, 0);
    check({tag, "_out_tdata"}, out_tdata, 0);
    check({tag, "_out_tlast"}, out_tlast, 0);
    check({tag, "_pkt_count"}, pkt_count, 0);
    check({tag, "_err_oversize"}, err_oversize, 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every output handshake, checks stall
  // stability and a reference occupancy of the output buffer.
  initial begin
    exp_t        e;
    logic        prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;
    int          occ;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    occ        = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        occ        = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", out_tvalid, 1);
          check("stall_data", {out_tlast, out_tdata}, {prev_last, prev_data});
        end
        if (out_tvalid && out_tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got 0x%0h last %0b, expected no output", out_tdata, out_tlast);
          end else begin
            e = exp_q.pop_front();
            check("out_tdata", out_tdata, e.d);
            check("out_tlast", out_tlast, e.l);
          end
        end
        occ = occ + ((|(in_tvalid & in_tready)) ? 1 : 0) - ((out_tvalid && out_tready) ? 1 : 0);
        check("skid_occupancy_le_2", (occ <= 2), 1);
        prev_stall = out_tvalid && !out_tready;
        prev_data  = out_tdata;
        prev_last  = out_tlast;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int lat;
    int c;
    logic got;

    rst_n      = 1'b0;
    en         = 1'b0;
    out_tready = 1'b1;
    for (int i = 0; i < N; i++) begin
      tv[i]   = 1'b0;
      td[i]   = '0;
      tl[i]   = 1'b0;
      tdst[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single packet from input 2 and latency to first output valid
    expect_word(16'h1111, 1'b0);
    expect_word(16'h2222, 1'b0);
    expect_word(16'h3333, 1'b1);
    t0  = cyc;
    lat = -1;
    fork
      drive_pkt(2, 16'h1111, 16'h1111, 3, 2'd0);
      begin
        for (int k = 0; k < 20 && lat < 0; k++) begin
          @(negedge clk);
          if (out_tvalid) lat = cyc - t0;
        end
      end
    join
    check("first_out_latency", lat, 2);
    drain("single_drain");
    check("single_pkt_count", pkt_count, 1);
    check("single_err_oversize", err_oversize, 0);

    // Fairness: inputs 0 and 1 each offer two back-to-back 2-word packets
    expect_word(16'hA000, 1'b0);
    expect_word(16'hA001, 1'b1);
    expect_word(16'hB000, 1'b0);
    expect_word(16'hB001, 1'b1);
    expect_word(16'hA010, 1'b0);
    expect_word(16'hA011, 1'b1);
    expect_word(16'hB010, 1'b0);
    expect_word(16'hB011, 1'b1);
    fork
      begin
        drive_pkt(0, 16'hA000, 16'h0001, 2, 2'd0);
        drive_pkt(0, 16'hA010, 16'h0001, 2, 2'd0);
      end
      begin
        drive_pkt(1, 16'hB000, 16'h0001, 2, 2'd0);
        drive_pkt(1, 16'hB010, 16'h0001, 2, 2'd0);
      end
    join
    drain("fair_drain");
    check("fair_pkt_count", pkt_count, 5);

    // Destination filter: input 3 targets another port
    tv[3]   = 1'b1;
    td[3]   = 16'hEEEE;
    tl[3]   = 1'b1;
    tdst[3] = 2'd1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("dest_in_tready3", in_tready[3], 0);
    end
    @(posedge clk);
    #1;
    tv[3] = 1'b0;
    tl[3] = 1'b0;
    drain("dest_drain");
    check("dest_pkt_count", pkt_count, 5);

    // Backpressure: 8-word packet (exactly MAX_PKT_WORDS, not forced)
    for (int k = 0; k < 8; k++) expect_word(16'h5000 + 16'(k), (k == 7));
    fork
      drive_pkt(1, 16'h5000, 16'h0001, 8, 2'd0);
      begin
        for (int j = 0; j < 60; j++) begin
          out_tready = (j % 3 == 0);
          @(posedge clk);
          #1;
        end
        out_tready = 1'b1;
      end
    join
    drain("bp_drain");
    check("bp_pkt_count", pkt_count, 6);
    check("bp_err_oversize", err_oversize, 0);

    // Oversize: 10 words with tlast on word 10 -> 8 forced + 2
    for (int k = 0; k < 8; k++) expect_word(16'hC000 + 16'(k), (k == 7));
    expect_word(16'hC008, 1'b0);
    expect_word(16'hC009, 1'b1);
    drive_pkt(0, 16'hC000, 16'h0001, 10, 2'd0);
    drain("oversize_drain");
    check("oversize_pkt_count", pkt_count, 8);
    check("oversize_err", err_oversize, 1);

    // Asynchronous reset while word 2 of 5 is being offered
    tv[1]   = 1'b1;
    td[1]   = 16'hD000;
    tl[1]   = 1'b0;
    tdst[1] = 2'd0;
    c   = 0;
    got = 1'b0;
    while (!got && c < 50) begin
      @(negedge clk);
      got = in_tready[1];
      @(posedge clk);
      #1;
      c++;
    end
    check("rst_first_word_accepted", got, 1);
    td[1] = 16'hD001;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tv[1] = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_word(16'hF000, 1'b0);
    expect_word(16'hF001, 1'b1);
    drive_pkt(1, 16'hF000, 16'h0001, 2, 2'd0);
    drain("post_rst_drain");
    check("post_rst_pkt_count", pkt_count, 1);
    check("post_rst_err_oversize", err_oversize, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
